fp_add_seq: RTL



---
 rtl/fp_pkg.sv | 25 ++
 rtl/lzc_24.sv | 24 ++
 rtl/fp_add_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 add/subtract sequencer.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int ADD_W   = 25;
  localparam int EXP_MAX = 255;

  // Bit positions of the binary32 fields.
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ISSUE,
    RELEASE,
    NORM,
    RESP,
    WAIT_LOW
  } state_t;

endpackage

// File: rtl/lzc_24.sv
// Combinational 24-bit leading-zero counter; valid is low when the input is zero.
module lzc_24 (
  input  logic [23:0] din,
  output logic [4:0]  cnt,
  output logic        valid
);

  logic found;

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && din[i]) begin
        cnt   = 5'(23 - i);
        found = 1'b1;
      end
    end
  end

  assign valid = |din;

endmodule

// File: rtl/fp_add_seq.sv
// Binary32 add/subtract sequencer: aligns operands, drives the 25-bit adder
// over REQ/ACK, normalizes (truncating) and returns the packed sum.
module fp_add_seq
  import fp_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [31:0] Z,
  output logic        ACK,
  output logic        ADD_REQ,
  output logic [24:0] ADD_A,
  output logic [24:0] ADD_B,
  input  logic [24:0] ADD_Z,
  input  logic        ADD_COUT,
  input  logic        ADD_ACK
);

  state_t             state;
  logic [31:0]        xr, yr;
  logic [EXP_W-1:0]   exp_big;
  logic               sign_big;
  logic               eff_sub;
  logic [ADD_W-1:0]   sum_z;
  logic               sum_cout;

  // Alignment datapath, evaluated from the captured operands during ALIGN.
  logic [EXP_W-1:0]   exp_x, exp_y, exp_b, exp_s, d;
  logic [MAN_W:0]     man_x, man_y, man_b, man_s, sm;
  logic               x_big, sign_b, eff_sub_c;

  assign exp_x = xr[EXP_HI:EXP_LO];
  assign exp_y = yr[EXP_HI:EXP_LO];
  assign man_x = (exp_x != '0) ? {1'b1, xr[MAN_HI:0]} : '0;
  assign man_y = (exp_y != '0) ? {1'b1, yr[MAN_HI:0]} : '0;

  assign x_big     = xr[EXP_HI:0] >= yr[EXP_HI:0];
  assign exp_b     = x_big ? exp_x : exp_y;
  assign exp_s     = x_big ? exp_y : exp_x;
  assign man_b     = x_big ? man_x : man_y;
  assign man_s     = x_big ? man_y : man_x;
  assign sign_b    = x_big ? xr[SIGN_BIT] : yr[SIGN_BIT];
  assign eff_sub_c = xr[SIGN_BIT] ^ yr[SIGN_BIT];
  assign d         = exp_b - exp_s;
  assign sm        = (d >= EXP_W'(MAN_W + 1)) ? '0 : (man_s >> d);

  // Normalization datapath, evaluated from the captured adder sum during NORM.
  logic [4:0]         lz;
  logic               nz;
  logic [MAN_W-1:0]   norm_man;
  logic [31:0]        z_norm;

  lzc_24 u_lzc (
    .din   (sum_z[23:0]),
    .cnt   (lz),
    .valid (nz)
  );

  always_comb begin
    z_norm   = '0;
    norm_man = sum_z[22:0] << lz;
    if (!eff_sub) begin
      // A carry out of the 24-bit mantissa field shifts the result right by one.
      if (sum_z[24] | sum_cout) begin
        if (exp_big == EXP_W'(EXP_MAX - 1))
          z_norm = {sign_big, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
          z_norm = {sign_big, exp_big + 8'd1, sum_z[23:1]};
      end else if (sum_z[23:0] != '0) begin
        z_norm = {sign_big, exp_big, sum_z[22:0]};
      end
    end else if (nz) begin
      if ({3'b000, lz} >= exp_big)
        z_norm = {sign_big, 31'b0};
      else
        z_norm = {sign_big, exp_big - {3'b000, lz}, norm_man};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      xr       <= '0;
      yr       <= '0;
      exp_big  <= '0;
      sign_big <= 1'b0;
      eff_sub  <= 1'b0;
      sum_z    <= '0;
      sum_cout <= 1'b0;
      Z        <= '0;
      ACK      <= 1'b0;
      ADD_REQ  <= 1'b0;
      ADD_A    <= '0;
      ADD_B    <= '0;
    end else begin
      ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            xr    <= X;
            yr    <= Y;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          ADD_A    <= {1'b0, man_b};
          ADD_B    <= eff_sub_c ? (~{1'b0, sm} + 25'd1) : {1'b0, sm};
          exp_big  <= exp_b;
          sign_big <= sign_b;
          eff_sub  <= eff_sub_c;
          ADD_REQ  <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (ADD_ACK) begin
            sum_z    <= ADD_Z;
            sum_cout <= ADD_COUT;
            ADD_REQ  <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: state <= NORM;
        NORM: begin
          Z     <= z_norm;
          ACK   <= 1'b1;
          state <= RESP;
        end
        RESP: state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!REQ) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
